// File: rtl/mod_reduce_if.sv
`default_nettype none
// ============================================================================
// Module   : mod_reduce_if
// Purpose  : Request/result bundle for mod_reduce. The requester drives start
//            and the operands. The reducer returns R, busy and done.
//            Optional macro MOD_REDUCE_SUB_EN adds the 'sub' request bit.
// Revision : 1.0  initial release
// ============================================================================
interface mod_reduce_if;
  logic         start;
  logic [384:0] S;
  logic [383:0] M;
`ifdef MOD_REDUCE_SUB_EN
  logic         sub;
`endif
  logic [383:0] R;
  logic         busy;
  logic         done;

  modport master (
    output start, S, M,
`ifdef MOD_REDUCE_SUB_EN
    output sub,
`endif
    input  R, busy, done
  );

  modport slave (
    input  start, S, M,
`ifdef MOD_REDUCE_SUB_EN
    input  sub,
`endif
    output R, busy, done
  );
endinterface
`default_nettype wire

// File: rtl/mod_reduce.sv
`default_nettype none
// ============================================================================
// Module   : mod_reduce
// Purpose  : Final conditional-subtract reduction of a 385-bit sum S (< 2M)
//            modulo a 384-bit M. The datapath works CHUNK bits per cycle,
//            least significant chunk first. The result R is S-M when that
//            does not underflow, otherwise S.
//            Optional macro MOD_REDUCE_SUB_EN adds a 'sub' mode. In that mode
//            S is a signed difference, and M is added back when S is negative.
// Revision : 1.0  initial release
// ============================================================================
module mod_reduce #(
  parameter int CHUNK = 128
) (
  input  logic        clk,
  input  logic        resetn,   // synchronous, active-high
  mod_reduce_if.slave bus
);

  localparam int c_WIDTH = 384;
  localparam int c_NCH   = c_WIDTH / CHUNK;
  localparam int c_CW    = (c_NCH > 1) ? $clog2(c_NCH) : 1;
  localparam logic [c_CW-1:0] c_LAST = c_CW'(c_NCH - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } state_t;

  state_t         r_state;
  logic [384:0]   r_s;
  logic [383:0]   r_m;
  logic [383:0]   r_d;
  logic [c_CW-1:0] r_cnt;
  logic           r_carry;      // borrow in subtract mode, carry in add mode
  logic [383:0]   r_r;
  logic           r_busy;
  logic           r_done;
`ifdef MOD_REDUCE_SUB_EN
  logic           r_sub;
`endif

  int             w_lsb;
  logic [CHUNK-1:0] w_s_chunk;
  logic [CHUNK-1:0] w_m_chunk;
  logic [CHUNK:0] w_res;        // bit CHUNK is the outgoing borrow/carry
  logic [383:0]   w_d_next;
  logic           w_use_d;

  // Process one chunk. Also build the full D that includes this chunk, so the
  // last RUN cycle can register R directly.
  always_comb begin
    w_lsb     = int'(r_cnt) * CHUNK;
    w_s_chunk = r_s[w_lsb +: CHUNK];
    w_m_chunk = r_m[w_lsb +: CHUNK];
    w_res     = {1'b0, w_s_chunk} - {1'b0, w_m_chunk} - {{CHUNK{1'b0}}, r_carry};
`ifdef MOD_REDUCE_SUB_EN
    if (r_sub) begin
      w_res = {1'b0, w_s_chunk} + {1'b0, w_m_chunk} + {{CHUNK{1'b0}}, r_carry};
    end
`endif
    w_d_next = r_d;
    w_d_next[w_lsb +: CHUNK] = w_res[CHUNK-1:0];
    // Keep S-M unless it underflowed. A set carry bit 384 means S >= 2^384 > M,
    // so the subtraction is always valid in that case.
    w_use_d = r_s[384] | ~w_res[CHUNK];
`ifdef MOD_REDUCE_SUB_EN
    // A negative difference (sign bit set) needs M added back.
    if (r_sub) begin
      w_use_d = r_s[384];
    end
`endif
  end

  // Control FSM with latched operands and registered busy/done/R.
  always_ff @(posedge clk) begin
    if (resetn) begin
      r_state <= ST_IDLE;
      r_s     <= '0;
      r_m     <= '0;
      r_d     <= '0;
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_r     <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
`ifdef MOD_REDUCE_SUB_EN
      r_sub   <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (bus.start) begin
            r_s     <= bus.S;
            r_m     <= bus.M;
            r_cnt   <= '0;
            r_carry <= 1'b0;
            r_busy  <= 1'b1;
`ifdef MOD_REDUCE_SUB_EN
            r_sub   <= bus.sub;
`endif
            r_state <= ST_RUN;
          end
        end
        ST_RUN: begin
          r_d     <= w_d_next;
          r_carry <= w_res[CHUNK];
          r_cnt   <= r_cnt + 1'b1;
          if (r_cnt == c_LAST) begin
            r_r     <= w_use_d ? w_d_next : r_s[383:0];
            r_done  <= 1'b1;
            r_state <= ST_FIN;
          end
        end
        ST_FIN: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.R    = r_r;
  assign bus.busy = r_busy;
  assign bus.done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_mod_reduce.sv
`default_nettype none
// ============================================================================
// Module   : tb_mod_reduce
// Purpose  : Directed and random checks of mod_reduce against S mod M,
//            including cycle-exact busy/done timing and reset abort.
//            Honours MOD_REDUCE_SUB_EN when defined.
// Revision : 1.0  initial release
// ============================================================================
module tb_mod_reduce;

  logic clk;
  logic resetn;
  int   n_pass;
  int   n_total;

  mod_reduce_if bus ();

  mod_reduce #(.CHUNK(128)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [383:0] obs, input logic [383:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic logic [383:0] rand384();
    logic [383:0] r;
    for (int i = 0; i < 12; i++) r[i*32 +: 32] = $urandom();
    return r;
  endfunction

  // Reference result: the mathematical remainder of S divided by M.
  function automatic logic [383:0] ref_mod(input logic [384:0] s, input logic [383:0] m);
    logic [384:0] r;
    r = s % {1'b0, m};
    return r[383:0];
  endfunction

  // Reference for signed-difference mode: a value in [-M, M) mapped into [0, M).
  function automatic logic [383:0] ref_sub(input logic [384:0] s, input logic [383:0] m);
    logic signed [386:0] v;
    v = signed'({{2{s[384]}}, s});
    if (v < 0) v = v + signed'({3'b000, m});
    return v[383:0];
  endfunction

  // One operation: one-cycle start, then cycle-exact busy/done checks.
  // Operands are scrambled after acceptance. Stray starts go in during RUN and FIN.
  task automatic do_op(input string tag, input logic [384:0] s, input logic [383:0] m,
                       input logic sb, input logic [383:0] exp);
    @(negedge clk);
    bus.start = 1'b1;
    bus.S     = s;
    bus.M     = m;
`ifdef MOD_REDUCE_SUB_EN
    bus.sub   = sb;
`else
    if (sb) $display("note: sub ignored in this build (%s)", tag);
`endif
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.S     = {1'b1, rand384()};
    bus.M     = rand384();
    for (int k = 1; k <= 4; k++) begin
      bus.start = (k == 2 || k == 4);
      chk({tag, ":busy"}, 384'(bus.busy), 384'(1'b1));
      chk({tag, ":done"}, 384'(bus.done), 384'(k == 4));
      if (k == 4) chk({tag, ":R"}, bus.R, exp);
      @(posedge clk); #1;
    end
    bus.start = 1'b0;
    chk({tag, ":busy_off"}, 384'(bus.busy), 384'(1'b0));
    chk({tag, ":done_off"}, 384'(bus.done), 384'(1'b0));
    chk({tag, ":R_hold"}, bus.R, exp);
  endtask

  initial begin
    logic [383:0] m;
    logic [384:0] s;
    logic [384:0] two_m;
    n_pass  = 0;
    n_total = 0;
    resetn    = 1'b1;
    bus.start = 1'b0;
    bus.S     = '0;
    bus.M     = '0;
`ifdef MOD_REDUCE_SUB_EN
    bus.sub   = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    chk("reset:R", bus.R, '0);
    chk("reset:busy", 384'(bus.busy), '0);
    chk("reset:done", 384'(bus.done), '0);
    resetn = 1'b0;

    // Directed cases with a large odd modulus.
    m = 384'd5;
    m[383] = 1'b1;
    do_op("s_eq_m", {1'b0, m}, m, 1'b0, ref_mod({1'b0, m}, m));
    do_op("s_2m_1", {m, 1'b0} - 385'd1, m, 1'b0, ref_mod({m, 1'b0} - 385'd1, m));
    do_op("s_m_1", {1'b0, m} - 385'd1, m, 1'b0, ref_mod({1'b0, m} - 385'd1, m));
    m = '1;
    s = '0;
    s[384] = 1'b1;
    do_op("borrow_chain", s, m, 1'b0, ref_mod(s, m));

    // Boundary cases on a random modulus.
    m = rand384() >> $urandom_range(0, 300);
    if (m == '0) m = 384'd1;
    two_m = {m, 1'b0};
    do_op("bnd_m", {1'b0, m}, m, 1'b0, '0);
    do_op("bnd_m_1", {1'b0, m} - 385'd1, m, 1'b0, m - 384'd1);
    do_op("bnd_0", '0, m, 1'b0, '0);
    do_op("bnd_2m_1", two_m - 385'd1, m, 1'b0, m - 384'd1);

    // Hold start high. Expect one operation every 5 cycles, with S disturbed
    // mid-operation.
    @(negedge clk);
    bus.start = 1'b1;
    bus.S     = 385'd5;
    bus.M     = 384'd3;
    @(posedge clk); #1;
    for (int k = 1; k <= 14; k++) begin
      if (k == 1) bus.S = '0;
      if (k == 3) bus.S = 385'd5;
      chk("hold:busy", 384'(bus.busy), 384'((k % 5) != 0));
      chk("hold:done", 384'(bus.done), 384'((k % 5) == 4));
      if ((k % 5) == 4) chk("hold:R", bus.R, ref_mod(385'd5, 384'd3));
      @(posedge clk); #1;
    end
    bus.start = 1'b0;

    // Reset in the second RUN cycle aborts the operation, and the next start
    // is accepted.
    @(negedge clk);
    bus.start = 1'b1;
    bus.S     = 385'd5;
    bus.M     = 384'd3;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
    @(posedge clk); #1;
    resetn = 1'b0;
    chk("abort:R", bus.R, '0);
    chk("abort:busy", 384'(bus.busy), '0);
    chk("abort:done", 384'(bus.done), '0);
    do_op("after_abort", 385'd4, 384'd3, 1'b0, ref_mod(385'd4, 384'd3));

    // Random operands that satisfy 0 <= S < 2M.
    for (int i = 0; i < 24; i++) begin
      m = rand384() >> $urandom_range(0, 383);
      if (m == '0) m = 384'd1;
      s = {rand384(), 1'b0} ^ 385'($urandom());
      s = s % {m, 1'b0};
      do_op("rand", s, m, 1'b0, ref_mod(s, m));
    end

`ifdef MOD_REDUCE_SUB_EN
    s = '1;
    s[0] = 1'b0;
    do_op("sub_neg", s, 384'd7, 1'b1, ref_sub(s, 384'd7));
    do_op("sub_pos", 385'd3, 384'd7, 1'b1, ref_sub(385'd3, 384'd7));
    for (int i = 0; i < 8; i++) begin
      m = rand384() >> $urandom_range(0, 383);
      if (m == '0) m = 384'd1;
      s = {rand384(), 1'b0} % {m, 1'b0};
      s = s - {1'b0, m};
      do_op("sub_rand", s, m, 1'b1, ref_sub(s, m));
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
